mem_bus_arbiter: RTL and testbench

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/mem_bus_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_bus_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one single-port memory between a fetch (read-only) port and a data port.
// Each access holds the memory for LAT cycles, then a one-cycle DONE state carries the rvalid pulse.
module mem_bus_arbiter #(
  parameter int LAT    = 2,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [7:0]        f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [7:0]        d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [7:0]        mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  typedef enum logic {PORT_F, PORT_D} port_t;

  localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

  state_t              r_state;
  state_t              w_nextState;
  port_t               r_owner;
  port_t               r_lastGrant;
  logic [3:0]          r_cnt;
  logic                r_we;
  logic [7:0]          r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_fRdata;
  logic [DATA_W-1:0]   r_dRdata;
  logic                w_arb;
  logic                w_fWin;
  logic                w_dWin;
  logic                w_access;
  logic                w_done;
  logic                w_first;

  // On a tie the port that was not granted last wins, so neither side waits more than one foreign access.
  assign w_arb  = (r_state != ACCESS);
  assign w_fWin = w_arb && f_req && (!d_req || (r_lastGrant == PORT_D));
  assign w_dWin = w_arb && d_req && (!f_req || (r_lastGrant == PORT_F));

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_fWin || w_dWin) w_nextState = ACCESS;
      ACCESS:  if (r_cnt == 4'd0) w_nextState = DONE;
      DONE:    w_nextState = (w_fWin || w_dWin) ? ACCESS : IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner     <= PORT_F;
      r_lastGrant <= PORT_F;
      r_cnt       <= 4'd0;
      r_we        <= 1'b0;
      r_addr      <= 8'd0;
      r_wdata     <= '0;
      r_fRdata    <= '0;
      r_dRdata    <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (w_dWin) begin
            r_owner     <= PORT_D;
            r_lastGrant <= PORT_D;
            r_we        <= d_we;
            r_addr      <= d_addr;
            r_wdata     <= d_wdata;
            r_cnt       <= CNT_INIT;
          end else if (w_fWin) begin
            r_owner     <= PORT_F;
            r_lastGrant <= PORT_F;
            r_we        <= 1'b0;
            r_addr      <= f_addr;
            r_cnt       <= CNT_INIT;
          end
        end
        ACCESS: begin
          // Memory data is taken on the last access cycle; writes leave the data-side read register alone.
          if (r_cnt == 4'd0) begin
            if (r_owner == PORT_F) r_fRdata <= mem_rdata;
            else if (!r_we)        r_dRdata <= mem_rdata;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign w_access = (r_state == ACCESS);
  assign w_done   = (r_state == DONE);
  assign w_first  = w_access && (r_cnt == CNT_INIT);

  assign f_gnt     = w_first && (r_owner == PORT_F);
  assign d_gnt     = w_first && (r_owner == PORT_D);
  assign f_rvalid  = w_done && (r_owner == PORT_F);
  assign d_rvalid  = w_done && (r_owner == PORT_D);
  assign f_rdata   = r_fRdata;
  assign d_rdata   = r_dRdata;
  assign mem_en    = w_access;
  assign mem_we    = w_access && r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a LAT=2 instance for the main scenarios, a LAT=1 instance for back-to-back reads.
// Both memories answer with rdata = addr ^ 8'hB5, so expected read data is computed by hand.
module tb_mem_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       f_req, d_req, d_we;
  logic [7:0] f_addr, d_addr, d_wdata;
  logic       f_gnt, f_rvalid, d_gnt, d_rvalid, mem_en, mem_we, busy;
  logic [7:0] f_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

  logic       l1FReq, l1DReq, l1DWe;
  logic [7:0] l1FAddr, l1DAddr, l1DWdata;
  logic       l1FGnt, l1FRvalid, l1DGnt, l1DRvalid, l1MemEn, l1MemWe, l1Busy;
  logic [7:0] l1FRdata, l1DRdata, l1MemAddr, l1MemWdata, l1MemRdata;

  int testCount = 0;
  int failCount = 0;
  int rvalidCount;
  int enCount;

  always #5 clk = ~clk;

  assign mem_rdata  = mem_addr ^ 8'hB5;
  assign l1MemRdata = l1MemAddr ^ 8'hB5;

  mem_bus_arbiter #(.LAT(2), .DATA_W(8)) dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_bus_arbiter #(.LAT(1), .DATA_W(8)) dutLat1 (
    .clk(clk), .rst(rst),
    .f_req(l1FReq), .f_addr(l1FAddr), .f_gnt(l1FGnt), .f_rvalid(l1FRvalid), .f_rdata(l1FRdata),
    .d_req(l1DReq), .d_we(l1DWe), .d_addr(l1DAddr), .d_wdata(l1DWdata),
    .d_gnt(l1DGnt), .d_rvalid(l1DRvalid), .d_rdata(l1DRdata),
    .mem_en(l1MemEn), .mem_we(l1MemWe), .mem_addr(l1MemAddr), .mem_wdata(l1MemWdata),
    .mem_rdata(l1MemRdata), .busy(l1Busy)
  );

  task automatic advanceCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  initial begin
    rst = 1'b1;
    f_req = 1'b0; f_addr = 8'h00; d_req = 1'b0; d_we = 1'b0; d_addr = 8'h00; d_wdata = 8'h00;
    l1FReq = 1'b0; l1FAddr = 8'h00; l1DReq = 1'b0; l1DWe = 1'b0; l1DAddr = 8'h00; l1DWdata = 8'h00;
    advanceCycle();
    advanceCycle();
    rst = 1'b0;

    checkOutput("rst_f_gnt", 32'(f_gnt), 32'd0);
    checkOutput("rst_d_gnt", 32'(d_gnt), 32'd0);
    checkOutput("rst_f_rvalid", 32'(f_rvalid), 32'd0);
    checkOutput("rst_d_rvalid", 32'(d_rvalid), 32'd0);
    checkOutput("rst_mem_en", 32'(mem_en), 32'd0);
    checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
    checkOutput("rst_f_rdata", 32'(f_rdata), 32'd0);
    checkOutput("rst_d_rdata", 32'(d_rdata), 32'd0);
    checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);

    // Single fetch read at 0x10, memory answers 0xA5
    f_req = 1'b1; f_addr = 8'h10;
    advanceCycle();
    checkOutput("rd_f_gnt_c1", 32'(f_gnt), 32'd1);
    checkOutput("rd_d_gnt_c1", 32'(d_gnt), 32'd0);
    checkOutput("rd_mem_en_c1", 32'(mem_en), 32'd1);
    checkOutput("rd_mem_we_c1", 32'(mem_we), 32'd0);
    checkOutput("rd_mem_addr_c1", 32'(mem_addr), 32'h10);
    checkOutput("rd_busy_c1", 32'(busy), 32'd1);
    advanceCycle();
    checkOutput("rd_f_gnt_c2", 32'(f_gnt), 32'd0);
    checkOutput("rd_mem_en_c2", 32'(mem_en), 32'd1);
    checkOutput("rd_f_rvalid_c2", 32'(f_rvalid), 32'd0);
    advanceCycle();
    checkOutput("rd_f_rvalid_c3", 32'(f_rvalid), 32'd1);
    checkOutput("rd_f_rdata_c3", 32'(f_rdata), 32'hA5);
    checkOutput("rd_mem_en_c3", 32'(mem_en), 32'd0);
    f_req = 1'b0;
    advanceCycle();
    checkOutput("rd_busy_idle", 32'(busy), 32'd0);
    checkOutput("rd_f_rvalid_idle", 32'(f_rvalid), 32'd0);
    checkOutput("rd_f_rdata_hold", 32'(f_rdata), 32'hA5);
    checkOutput("rd_mem_addr_hold", 32'(mem_addr), 32'h10);

    // Data-side write: d_rdata must stay at its reset value
    d_req = 1'b1; d_we = 1'b1; d_addr = 8'h3C; d_wdata = 8'h5A;
    advanceCycle();
    checkOutput("wr_d_gnt_c1", 32'(d_gnt), 32'd1);
    checkOutput("wr_mem_we_c1", 32'(mem_we), 32'd1);
    checkOutput("wr_mem_addr_c1", 32'(mem_addr), 32'h3C);
    checkOutput("wr_mem_wdata_c1", 32'(mem_wdata), 32'h5A);
    advanceCycle();
    checkOutput("wr_mem_we_c2", 32'(mem_we), 32'd1);
    checkOutput("wr_mem_en_c2", 32'(mem_en), 32'd1);
    advanceCycle();
    checkOutput("wr_d_rvalid_c3", 32'(d_rvalid), 32'd1);
    checkOutput("wr_d_rdata_c3", 32'(d_rdata), 32'h00);
    checkOutput("wr_mem_we_c3", 32'(mem_we), 32'd0);
    checkOutput("wr_mem_wdata_hold", 32'(mem_wdata), 32'h5A);
    d_req = 1'b0; d_we = 1'b0;
    advanceCycle();

    // Simultaneous requests after reset: data first, then fetch with no idle cycle, then data again
    rst = 1'b1;
    advanceCycle();
    rst = 1'b0;
    f_req = 1'b1; f_addr = 8'h20; d_req = 1'b1; d_addr = 8'h30;
    advanceCycle();
    checkOutput("tie1_d_gnt", 32'(d_gnt), 32'd1);
    checkOutput("tie1_f_gnt", 32'(f_gnt), 32'd0);
    checkOutput("tie1_mem_addr", 32'(mem_addr), 32'h30);
    advanceCycle();
    advanceCycle();
    checkOutput("tie1_d_rvalid", 32'(d_rvalid), 32'd1);
    checkOutput("tie1_d_rdata", 32'(d_rdata), 32'h85);
    checkOutput("tie1_f_rvalid", 32'(f_rvalid), 32'd0);
    advanceCycle();
    checkOutput("tie2_f_gnt", 32'(f_gnt), 32'd1);
    checkOutput("tie2_d_gnt", 32'(d_gnt), 32'd0);
    checkOutput("tie2_busy", 32'(busy), 32'd1);
    checkOutput("tie2_mem_addr", 32'(mem_addr), 32'h20);
    advanceCycle();
    advanceCycle();
    checkOutput("tie2_f_rvalid", 32'(f_rvalid), 32'd1);
    checkOutput("tie2_f_rdata", 32'(f_rdata), 32'h95);
    advanceCycle();
    checkOutput("tie3_d_gnt", 32'(d_gnt), 32'd1);
    checkOutput("tie3_f_gnt", 32'(f_gnt), 32'd0);
    advanceCycle();
    advanceCycle();
    checkOutput("tie3_d_rvalid", 32'(d_rvalid), 32'd1);
    d_req = 1'b0;

    // Fetch address moves mid-access; the latched address must persist
    advanceCycle();
    checkOutput("hold_f_gnt", 32'(f_gnt), 32'd1);
    f_addr = 8'h77;
    advanceCycle();
    checkOutput("hold_mem_addr_c2", 32'(mem_addr), 32'h20);
    checkOutput("hold_mem_en_c2", 32'(mem_en), 32'd1);
    advanceCycle();
    checkOutput("hold_f_rdata", 32'(f_rdata), 32'h95);
    checkOutput("hold_f_rvalid", 32'(f_rvalid), 32'd1);
    f_req = 1'b0;
    advanceCycle();

    // Reset in the second access cycle aborts the read; the held request is then served anew
    f_req = 1'b1; f_addr = 8'h44;
    advanceCycle();
    checkOutput("abort_f_gnt", 32'(f_gnt), 32'd1);
    advanceCycle();
    rst = 1'b1;
    advanceCycle();
    checkOutput("abort_mem_en", 32'(mem_en), 32'd0);
    checkOutput("abort_f_rvalid", 32'(f_rvalid), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_f_rdata", 32'(f_rdata), 32'h00);
    rst = 1'b0;
    advanceCycle();
    checkOutput("retry_f_gnt", 32'(f_gnt), 32'd1);
    checkOutput("retry_mem_addr", 32'(mem_addr), 32'h44);
    advanceCycle();
    checkOutput("retry_f_rvalid_c2", 32'(f_rvalid), 32'd0);
    advanceCycle();
    checkOutput("retry_f_rvalid_c3", 32'(f_rvalid), 32'd1);
    checkOutput("retry_f_rdata", 32'(f_rdata), 32'hF1);
    f_req = 1'b0;
    advanceCycle();

    // LAT=1: continuous data reads give one rvalid every other cycle
    l1DReq = 1'b1; l1DAddr = 8'h01;
    advanceCycle();
    checkOutput("lat1_d_gnt", 32'(l1DGnt), 32'd1);
    checkOutput("lat1_mem_en_c1", 32'(l1MemEn), 32'd1);
    advanceCycle();
    checkOutput("lat1_d_rvalid", 32'(l1DRvalid), 32'd1);
    checkOutput("lat1_d_rdata", 32'(l1DRdata), 32'hB4);
    checkOutput("lat1_mem_en_c2", 32'(l1MemEn), 32'd0);
    rvalidCount = 0;
    enCount = 0;
    for (int i = 0; i < 8; i++) begin
      advanceCycle();
      rvalidCount += int'(l1DRvalid);
      enCount += int'(l1MemEn);
    end
    checkOutput("lat1_rvalid_count", 32'(rvalidCount), 32'd4);
    checkOutput("lat1_en_count", 32'(enCount), 32'd4);
    l1DReq = 1'b0;
    advanceCycle();
    advanceCycle();
    checkOutput("lat1_busy_end", 32'(l1Busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
